// File: rtl/intr_pkg.sv
// Shared constants for the interrupt source conditioner: register offsets,
// MODE field positions and line count.
package intr_pkg;

  localparam int N_LINES = 4;

  localparam logic [1:0] IE_OFS     = 2'd0;
  localparam logic [1:0] MODE_OFS   = 2'd1;
  localparam logic [1:0] STAT_OFS   = 2'd2;
  localparam logic [1:0] SWTRIG_OFS = 2'd3;

  localparam int MODE_EDGE_LSB = 0;
  localparam int MODE_INV_LSB  = 4;

  typedef logic [N_LINES-1:0] line_vec_t;

endpackage

// File: rtl/intr_filt.sv
// One interrupt line: two-flop synchronizer followed by a glitch filter that
// only follows the synchronized pin after FILT_LEN consecutive disagreeing cycles.
module intr_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic filt
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = 4'd0;
    // The cycle that would bring the count to FILT_LEN flips the output instead.
    if (s2_q != filt_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/intr_src.sv
// Interrupt source conditioner: filtered pins, polarity/edge selection, sticky
// flags, software trigger and the interrupt enable register on the I/O bus.
module intr_src
  import intr_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h20,
  parameter int         FILT_LEN  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] irq_pin,
  input  logic [7:0] io_addr,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [7:0] io_wr_data,
  output logic [7:0] io_rd_data,
  output logic [3:0] ext_intr,
  output logic [3:0] intr_ena
);

  line_vec_t filt;

  for (genvar i = 0; i < N_LINES; i++) begin : g_line
    intr_filt #(.FILT_LEN(FILT_LEN)) u_filt (
      .clock (clock),
      .reset (reset),
      .pin   (irq_pin[i]),
      .filt  (filt[i])
    );
  end

  line_vec_t ie_q, ie_d;
  logic [7:0] mode_q, mode_d;
  line_vec_t act_dly_q, act_dly_d;
  line_vec_t flag_q, flag_d;
  line_vec_t ext_q, ext_d;

  logic [7:0] ofs;
  logic       hit;
  logic       wr_ie, wr_mode, wr_stat, wr_sw;
  line_vec_t  edge_en, inv, act, rise, swtrig, w1c;

  assign ofs     = io_addr - BASE_ADDR;
  assign hit     = (ofs[7:2] == 6'd0);
  assign wr_ie   = io_wr && hit && (ofs[1:0] == IE_OFS);
  assign wr_mode = io_wr && hit && (ofs[1:0] == MODE_OFS);
  assign wr_stat = io_wr && hit && (ofs[1:0] == STAT_OFS);
  assign wr_sw   = io_wr && hit && (ofs[1:0] == SWTRIG_OFS);

  assign edge_en = mode_q[MODE_EDGE_LSB +: N_LINES];
  assign inv     = mode_q[MODE_INV_LSB +: N_LINES];
  assign act     = filt ^ inv;
  assign rise    = act & ~act_dly_q;
  assign swtrig  = wr_sw ? io_wr_data[N_LINES-1:0] : '0;
  assign w1c     = wr_stat ? io_wr_data[N_LINES-1:0] : '0;

  always_comb begin
    ie_d   = wr_ie ? io_wr_data[N_LINES-1:0] : ie_q;
    mode_d = wr_mode ? io_wr_data : mode_q;
    // A MODE write reloads the delayed level with the post-write polarity so the
    // change itself never looks like a rising edge.
    act_dly_d = wr_mode ? (filt ^ io_wr_data[MODE_INV_LSB +: N_LINES]) : act;
    ext_d     = (edge_en & rise) | (~edge_en & act) | swtrig;
    // Set has priority over a same-cycle write-one-to-clear.
    flag_d    = (flag_q & ~w1c) | rise | swtrig;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie_q      <= '0;
      mode_q    <= 8'd0;
      act_dly_q <= '0;
      flag_q    <= '0;
      ext_q     <= '0;
    end else begin
      ie_q      <= ie_d;
      mode_q    <= mode_d;
      act_dly_q <= act_dly_d;
      flag_q    <= flag_d;
      ext_q     <= ext_d;
    end
  end

  always_comb begin
    io_rd_data = 8'd0;
    if (io_rd && hit) begin
      case (ofs[1:0])
        IE_OFS:   io_rd_data = {4'd0, ie_q};
        MODE_OFS: io_rd_data = mode_q;
        STAT_OFS: io_rd_data = {act, flag_q};
        default:  io_rd_data = 8'd0;
      endcase
    end
  end

  assign ext_intr = ext_q;
  assign intr_ena = ie_q;

endmodule

// File: tb/tb_intr_src.sv
// Directed bench for intr_src: the stimulus thread schedules expected values by
// cycle number into a queue; a negedge monitor pops and compares them.
module tb_intr_src;

  localparam logic [7:0] A_IE   = 8'h20;
  localparam logic [7:0] A_MODE = 8'h21;
  localparam logic [7:0] A_STAT = 8'h22;
  localparam logic [7:0] A_SW   = 8'h23;
  localparam int K_EXT = 0;
  localparam int K_ENA = 1;
  localparam int K_RD  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_pin = 4'd0;
  logic [7:0] io_addr = 8'd0;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [7:0] io_wr_data = 8'd0;
  logic [7:0] io_rd_data;
  logic [3:0] ext_intr;
  logic [3:0] intr_ena;

  intr_src #(.BASE_ADDR(8'h20), .FILT_LEN(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_pin    (irq_pin),
    .io_addr    (io_addr),
    .io_wr      (io_wr),
    .io_rd      (io_rd),
    .io_wr_data (io_wr_data),
    .io_rd_data (io_rd_data),
    .ext_intr   (ext_intr),
    .intr_ena   (intr_ena)
  );

  // clock / cycle counter
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard
  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [7:0]  val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_bad = 0;

  function automatic void push_exp(int c, int k, logic [7:0] v, string n);
    exp_t e;
    int   idx;
    e.cyc  = 32'(c);
    e.kind = 2'(k);
    e.val  = v;
    idx = exp_q.size();
    while (idx > 0 && int'(exp_q[idx-1].cyc) > c) idx--;
    exp_q.insert(idx, e);
    name_q.insert(idx, n);
  endfunction

  function automatic void exp_at(int delta, int k, logic [7:0] v, string n);
    push_exp(cyc + delta, k, v, n);
  endfunction

  always @(negedge clock) begin
    exp_t       e;
    string      n;
    logic [7:0] got;
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (int'(e.kind))
        K_EXT:   got = {4'd0, ext_intr};
        K_ENA:   got = {4'd0, intr_ena};
        default: got = io_rd_data;
      endcase
      n_chk++;
      if (int'(e.cyc) != cyc) begin
        n_bad++;
        $display("FAIL %s: check missed, scheduled cycle %0d, now %0d", n, e.cyc, cyc);
      end else if (got !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %02h expected %02h (cycle %0d)", n, got, e.val, cyc);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr    = a;
    io_wr_data = d;
    io_wr      = 1'b1;
    tick(1);
    io_wr      = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] v, input string n);
    io_addr = a;
    io_rd   = 1'b1;
    push_exp(cyc, K_RD, v, n);
    tick(1);
    io_rd   = 1'b0;
  endtask

  initial begin
    // reset state
    tick(3);
    exp_at(0, K_EXT, 8'h00, "rst_ext");
    exp_at(0, K_ENA, 8'h00, "rst_ena");
    reset = 1'b0;
    tick(2);
    rd_chk(A_STAT, 8'h00, "rst_stat");
    rd_chk(A_MODE, 8'h00, "rst_mode");

    // level mode on line 0
    irq_pin[0] = 1'b1;
    exp_at(6, K_EXT, 8'h00, "lvl_rise_early");
    exp_at(7, K_EXT, 8'h01, "lvl_rise");
    tick(7);
    rd_chk(A_STAT, 8'h11, "lvl_stat_hi");
    irq_pin[0] = 1'b0;
    exp_at(6, K_EXT, 8'h01, "lvl_fall_early");
    exp_at(7, K_EXT, 8'h00, "lvl_fall");
    tick(7);
    rd_chk(A_STAT, 8'h01, "lvl_flag_sticky");

    // edge mode on line 1, then W1C
    wr(A_MODE, 8'h02);
    irq_pin[1] = 1'b1;
    exp_at(6, K_EXT, 8'h00, "edge_early");
    exp_at(7, K_EXT, 8'h02, "edge_pulse");
    exp_at(8, K_EXT, 8'h00, "edge_width");
    tick(9);
    rd_chk(A_STAT, 8'h23, "edge_stat");
    wr(A_STAT, 8'h02);
    rd_chk(A_STAT, 8'h21, "w1c_flag1");
    wr(A_STAT, 8'h01);
    rd_chk(A_STAT, 8'h20, "w1c_flag0");

    // glitch rejection on line 2, then a 4-cycle pulse
    irq_pin[2] = 1'b1;
    exp_at(7, K_EXT, 8'h00, "glitch_rej_a");
    exp_at(9, K_EXT, 8'h00, "glitch_rej_b");
    tick(3);
    irq_pin[2] = 1'b0;
    tick(10);
    rd_chk(A_STAT, 8'h20, "glitch_no_flag");
    irq_pin[2] = 1'b1;
    exp_at(6,  K_EXT, 8'h00, "pulse4_early");
    exp_at(7,  K_EXT, 8'h04, "pulse4_acc");
    exp_at(10, K_EXT, 8'h04, "pulse4_hold");
    exp_at(11, K_EXT, 8'h00, "pulse4_end");
    tick(4);
    irq_pin[2] = 1'b0;
    tick(8);
    rd_chk(A_STAT, 8'h24, "pulse4_flag");
    wr(A_STAT, 8'h04);
    irq_pin[1] = 1'b0;
    tick(8);
    rd_chk(A_STAT, 8'h00, "idle_stat");

    // polarity change on line 3 while pin is high
    irq_pin[3] = 1'b1;
    exp_at(7, K_EXT, 8'h08, "inv_pre_level");
    tick(8);
    wr(A_STAT, 8'h08);
    exp_at(1, K_EXT, 8'h08, "inv_write_cycle");
    exp_at(2, K_EXT, 8'h00, "inv_act_fall");
    exp_at(4, K_EXT, 8'h00, "inv_no_spur");
    wr(A_MODE, 8'h80);
    tick(4);
    rd_chk(A_STAT, 8'h00, "inv_no_flag");
    rd_chk(A_MODE, 8'h80, "mode_readback");
    irq_pin[3] = 1'b0;
    exp_at(6, K_EXT, 8'h00, "inv_low_early");
    exp_at(7, K_EXT, 8'h08, "inv_low_active");
    tick(7);
    rd_chk(A_STAT, 8'h88, "inv_stat");
    exp_at(2, K_EXT, 8'h00, "mode_clear");
    wr(A_MODE, 8'h00);
    wr(A_STAT, 8'h0F);
    rd_chk(A_STAT, 8'h00, "all_clear");

    // set beats a same-cycle W1C
    wr(A_MODE, 8'h01);
    irq_pin[0] = 1'b1;
    exp_at(7, K_EXT, 8'h01, "edge0_pulse");
    tick(6);
    wr(A_STAT, 8'h01);
    rd_chk(A_STAT, 8'h11, "set_wins_w1c");
    irq_pin[0] = 1'b0;
    tick(8);
    wr(A_STAT, 8'h0F);
    rd_chk(A_STAT, 8'h00, "pre_sw_clear");

    // SWTRIG coinciding with an edge, W1C in the cycle before
    irq_pin[0] = 1'b1;
    exp_at(6, K_EXT, 8'h00, "sw_pre");
    exp_at(7, K_EXT, 8'h05, "sw_and_edge");
    exp_at(8, K_EXT, 8'h00, "sw_width");
    tick(5);
    wr(A_STAT, 8'h01);
    wr(A_SW, 8'h05);
    rd_chk(A_STAT, 8'h15, "sw_flags");
    rd_chk(A_SW, 8'h00, "sw_read_zero");

    // IE register, bus idle value, unmapped addresses
    exp_at(0, K_ENA, 8'h00, "ena_before");
    exp_at(1, K_ENA, 8'h0A, "ena_after");
    wr(A_IE, 8'hFA);
    rd_chk(A_IE, 8'h0A, "ie_read");
    io_addr = A_IE;
    push_exp(cyc, K_RD, 8'h00, "no_rd_zero");
    tick(1);
    rd_chk(8'h24, 8'h00, "unmapped_hi");
    rd_chk(8'h1F, 8'h00, "unmapped_lo");

    // asynchronous reset in the middle of a SWTRIG pulse
    wr(A_SW, 8'h0F);
    #2;
    reset   = 1'b1;
    io_addr = A_STAT;
    io_rd   = 1'b1;
    push_exp(cyc, K_EXT, 8'h00, "rst_ext_async");
    push_exp(cyc, K_ENA, 8'h00, "rst_ena_async");
    push_exp(cyc, K_RD,  8'h00, "rst_stat_async");
    tick(1);
    io_rd = 1'b0;
    reset = 1'b0;

    // pin 0 held active through reset release
    exp_at(1, K_ENA, 8'h00, "rel_ena");
    exp_at(6, K_EXT, 8'h00, "rel_early");
    exp_at(7, K_EXT, 8'h01, "rel_event");
    tick(8);
    rd_chk(A_STAT, 8'h11, "rel_stat");

    // drain and report
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d checks still pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
